// File: rtl/fork_event_scheduler.sv
// fork_event_scheduler: replays a programmable set of delayed register writes.
// Every enabled slot launches together on start. Each slot writes its value into
// the shared output register when its delay expires. The iteration ("join") ends
// when the longest delay expires. In repeat mode the next iteration starts on
// that same edge.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | slot table writable, waiting for start with >=1 enabled slot
// RUN   | elapsed counting, slots firing, join at elapsed == maxd
module fork_event_scheduler #(
  parameter int NSLOT = 2,
  parameter int WIDTH = 4,
  parameter int DW    = 8,
  localparam int SW   = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_slot,
  input  logic             cfg_en,
  input  logic [DW-1:0]    cfg_delay,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic             start,
  input  logic             repeat_mode,
  input  logic             stop,
  output logic [WIDTH-1:0] value,
  output logic [NSLOT-1:0] fire,
  output logic             join_pulse,
  output logic             busy,
  output logic [7:0]       iter_count,
  output logic             cfg_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;

  // Configuration table (written in IDLE only)
  logic             slot_en    [NSLOT];
  logic [DW-1:0]    slot_delay [NSLOT];
  logic [WIDTH-1:0] slot_value [NSLOT];

  // Snapshot used while running
  logic             run_en     [NSLOT];
  logic [DW-1:0]    run_delay  [NSLOT];
  logic [WIDTH-1:0] run_value  [NSLOT];

  logic [DW-1:0]    elapsed, elapsed_nxt, maxd, maxd_calc;
  logic             rep_q, any_en, launch, join_hit;
  logic [NSLOT-1:0] hit;
  logic [WIDTH-1:0] win_value;

  assign busy = (state == RUN);

  // Enabled-slot summary of the live table: any enabled, and the longest delay
  always_comb begin
    any_en    = 1'b0;
    maxd_calc = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_en[i]) begin
        any_en = 1'b1;
        if (slot_delay[i] > maxd_calc) maxd_calc = slot_delay[i];
      end
    end
  end

  // Per-edge fire detection; the highest-index hit wins the shared register
  always_comb begin
    elapsed_nxt = elapsed + 1'b1;
    join_hit    = (elapsed_nxt == maxd);
    hit         = '0;
    win_value   = value;
    for (int i = 0; i < NSLOT; i++) begin
      hit[i] = run_en[i] && (run_delay[i] == elapsed_nxt);
      if (hit[i]) win_value = run_value[i];
    end
  end

  // Next-state logic; stop wins over start and over a join
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop && any_en) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop)                   state_nxt = IDLE;
        else if (join_hit && !rep_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Slot table, snapshot, timing counter and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value      <= '0;
      fire       <= '0;
      join_pulse <= 1'b0;
      iter_count <= '0;
      cfg_err    <= 1'b0;
      elapsed    <= '0;
      maxd       <= '0;
      rep_q      <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_en[i]    <= 1'b0;
        slot_delay[i] <= DW'(1);
        slot_value[i] <= '0;
        run_en[i]     <= 1'b0;
        run_delay[i]  <= DW'(1);
        run_value[i]  <= '0;
      end
    end else begin
      fire       <= '0;
      join_pulse <= 1'b0;
      cfg_err    <= 1'b0;

      if (cfg_we) begin
        if (state == IDLE) begin
          if (int'(cfg_slot) < NSLOT) begin
            slot_en[cfg_slot]    <= cfg_en;
            slot_delay[cfg_slot] <= (cfg_delay == '0) ? DW'(1) : cfg_delay;
            slot_value[cfg_slot] <= cfg_value;
          end
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (launch) begin
        elapsed    <= '0;
        iter_count <= '0;
        rep_q      <= repeat_mode;
        maxd       <= maxd_calc;
        for (int i = 0; i < NSLOT; i++) begin
          run_en[i]    <= slot_en[i];
          run_delay[i] <= slot_delay[i];
          run_value[i] <= slot_value[i];
        end
      end else if (state == RUN && !stop) begin
        fire  <= hit;
        value <= win_value;
        if (join_hit) begin
          join_pulse <= 1'b1;
          elapsed    <= '0;
          if (iter_count != 8'hFF) iter_count <= iter_count + 8'd1;
        end else begin
          elapsed <= elapsed_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fork_event_scheduler.sv
// Scoreboard bench for fork_event_scheduler: each scenario pushes the expected
// per-cycle outputs (derived from the start-edge timing formulas) and pops them
// as the corresponding edges are reached.
module tb_fork_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [0:0] cfg_slot;
  logic       cfg_en;
  logic [7:0] cfg_delay;
  logic [3:0] cfg_value;
  logic       start, repeat_mode, stop;
  logic [3:0] value;
  logic [1:0] fire;
  logic       join_pulse, busy, cfg_err;
  logic [7:0] iter_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fork_event_scheduler #(.NSLOT(2), .WIDTH(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_en(cfg_en), .cfg_delay(cfg_delay), .cfg_value(cfg_value),
    .start(start), .repeat_mode(repeat_mode), .stop(stop),
    .value(value), .fire(fire), .join_pulse(join_pulse), .busy(busy),
    .iter_count(iter_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] get_sig(int id);
    case (id)
      0: return 32'(value);
      1: return 32'(fire);
      2: return 32'(join_pulse);
      3: return 32'(busy);
      4: return 32'(iter_count);
      default: return 32'(cfg_err);
    endcase
  endfunction

  function automatic string sig_name(int id);
    case (id)
      0: return "value";
      1: return "fire";
      2: return "join_pulse";
      3: return "busy";
      4: return "iter_count";
      default: return "cfg_err";
    endcase
  endfunction

  task automatic push(int cyc, int sig, logic [31:0] val);
    exp_t x;
    x.cyc = cyc; x.sig = sig; x.val = val;
    sb.push_back(x);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_en = 1'b0;
    cfg_delay = '0; cfg_value = '0; start = 1'b0; repeat_mode = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic write_slot(int s, logic en, logic [7:0] d, logic [3:0] v);
    cfg_we = 1'b1; cfg_slot = 1'(s); cfg_en = en; cfg_delay = d; cfg_value = v;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic launch(logic rep);
    start = 1'b1; repeat_mode = rep;
    @(posedge clk);
    #1 start = 1'b0; repeat_mode = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int s = 0; s < 6; s++) push(0, s, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); checks++;
      if (get_sig(e.sig) !== e.val) begin
        errors++;
        $display("FAIL reset %s: got %0h expected %0h", sig_name(e.sig), get_sig(e.sig), e.val);
      end
    end
    // all slots disabled after reset: start must be ignored
    launch(1'b1);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored busy: got %0b expected 0", busy);
    end
  endtask

  task automatic test_repeat();
    apply_reset();
    write_slot(0, 1'b1, 8'd5, 4'd1);
    write_slot(1, 1'b1, 8'd8, 4'd2);
    for (int t = 1; t <= 16; t++) begin
      if (t == 4)  push(t, 0, 32'd0);
      if (t == 6)  push(t, 0, 32'd1);
      if (t == 9)  push(t, 0, 32'd2);
      if (t == 14) push(t, 0, 32'd1);
      if (t == 16) push(t, 0, 32'd2);
      push(t, 1, {30'd0, (t % 8 == 0), (t % 8 == 5)});
      push(t, 2, 32'((t % 8) == 0));
      push(t, 3, 32'd1);
      push(t, 4, 32'(t / 8));
    end
    launch(1'b1);
    for (int t = 1; t <= 16; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); checks++;
        if (get_sig(e.sig) !== e.val) begin
          errors++;
          $display("FAIL repeat %s t=%0d: got %0h expected %0h", sig_name(e.sig), t, get_sig(e.sig), e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL repeat leftover: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_oneshot();
    apply_reset();
    write_slot(0, 1'b1, 8'd5, 4'd1);
    write_slot(1, 1'b1, 8'd8, 4'd2);
    for (int t = 1; t <= 40; t++) begin
      push(t, 0, (t < 5) ? 32'd0 : (t < 8) ? 32'd1 : 32'd2);
      push(t, 1, (t == 5) ? 32'd1 : (t == 8) ? 32'd2 : 32'd0);
      push(t, 2, 32'(t == 8));
      push(t, 3, 32'(t < 8));
      push(t, 4, 32'(t >= 8));
    end
    launch(1'b0);
    for (int t = 1; t <= 40; t++) begin
      start = (t == 8);        // coincides with the join edge: must be ignored
      repeat_mode = (t == 8);
      @(posedge clk); #1;
      start = 1'b0; repeat_mode = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); checks++;
        if (get_sig(e.sig) !== e.val) begin
          errors++;
          $display("FAIL oneshot %s t=%0d: got %0h expected %0h", sig_name(e.sig), t, get_sig(e.sig), e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL oneshot leftover: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    write_slot(0, 1'b1, 8'd3, 4'd4);
    write_slot(1, 1'b1, 8'd3, 4'd9);
    for (int t = 1; t <= 5; t++) begin
      push(t, 0, (t < 3) ? 32'd0 : 32'd9);
      push(t, 1, (t == 3) ? 32'd3 : 32'd0);
      push(t, 2, 32'(t == 3));
      push(t, 3, 32'(t < 3));
    end
    launch(1'b0);
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); checks++;
        if (get_sig(e.sig) !== e.val) begin
          errors++;
          $display("FAIL simultaneous %s t=%0d: got %0h expected %0h", sig_name(e.sig), t, get_sig(e.sig), e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL simultaneous leftover: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_zero_delay();
    apply_reset();
    write_slot(0, 1'b1, 8'd0, 4'd7);
    for (int t = 1; t <= 3; t++) begin
      push(t, 0, 32'd7);
      push(t, 1, (t == 1) ? 32'd1 : 32'd0);
      push(t, 2, 32'(t == 1));
      push(t, 3, 32'd0);
      push(t, 4, 32'd1);
    end
    launch(1'b0);
    for (int t = 1; t <= 3; t++) begin
      @(posedge clk); #1;
      while (sb.size() > 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); checks++;
        if (get_sig(e.sig) !== e.val) begin
          errors++;
          $display("FAIL zero_delay %s t=%0d: got %0h expected %0h", sig_name(e.sig), t, get_sig(e.sig), e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL zero_delay leftover: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_cfg_err_stop();
    apply_reset();
    write_slot(0, 1'b1, 8'd5, 4'd1);
    write_slot(1, 1'b1, 8'd8, 4'd2);
    for (int t = 1; t <= 12; t++) begin
      push(t, 0, (t < 5) ? 32'd0 : 32'd1);
      push(t, 1, (t == 5) ? 32'd1 : 32'd0);
      push(t, 2, 32'd0);
      push(t, 3, 32'(t < 6));
      push(t, 5, 32'(t == 3));
    end
    launch(1'b1);
    for (int t = 1; t <= 12; t++) begin
      cfg_we = (t == 3); cfg_slot = 1'b0; cfg_en = 1'b1; cfg_delay = 8'd2; cfg_value = 4'd15;
      stop = (t == 6);
      @(posedge clk); #1;
      cfg_we = 1'b0; stop = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); checks++;
        if (get_sig(e.sig) !== e.val) begin
          errors++;
          $display("FAIL cfg_err_stop %s t=%0d: got %0h expected %0h", sig_name(e.sig), t, get_sig(e.sig), e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL cfg_err_stop leftover: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    write_slot(0, 1'b1, 8'd5, 4'd1);
    write_slot(1, 1'b1, 8'd8, 4'd2);
    for (int t = 1; t <= 10; t++) begin
      push(t, 0, (t == 5) ? 32'd1 : 32'd0);
      push(t, 1, (t == 5) ? 32'd1 : 32'd0);
      push(t, 2, 32'd0);
      push(t, 3, 32'(t < 6));
      push(t, 4, 32'd0);
    end
    launch(1'b1);
    for (int t = 1; t <= 10; t++) begin
      rst_n = (t != 6);
      start = (t == 7);
      repeat_mode = (t == 7);
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0; repeat_mode = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == t) begin
        e = sb.pop_front(); checks++;
        if (get_sig(e.sig) !== e.val) begin
          errors++;
          $display("FAIL reset_midrun %s t=%0d: got %0h expected %0h", sig_name(e.sig), t, get_sig(e.sig), e.val);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_midrun leftover: got %0d pending expectations, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_repeat();
    test_oneshot();
    test_simultaneous();
    test_zero_delay();
    test_cfg_err_stop();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
